// File: rtl/vote_session_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vote_session_ctrl: one-session sequencer for a three-voter vote counter.    |
// | Optional ballot-window timeout: define VOTE_TIMEOUT_EN.   Revision: 1.0     |
// +-----------------------------------------------------------------------------+
module vote_session_ctrl #(
    parameter int TMO_W      = 4,
    parameter int TMO_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] cast,
    input  logic [2:0] choice,
    output logic [2:0] V,
    input  logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       majority,
    output logic [2:0] voted,
    output logic       dup_err,
    output logic       hot_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ballot;
    logic [2:0] r_voted;
    logic       r_dup_err;
    logic [3:0] r_result;
    logic       r_majority;
    logic       r_hot_err;

    logic [2:0] w_new_cast;
    logic [2:0] w_voted_nxt;
    logic       w_r_onehot;
    logic       w_close;

    assign w_new_cast  = cast & ~r_voted;
    assign w_voted_nxt = r_voted | cast;
    assign w_r_onehot  = (R != 4'b0000) && ((R & (R - 4'd1)) == 4'b0000);

`ifdef VOTE_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYCLES - 1));
    assign w_close   = (w_voted_nxt == 3'b111) || w_tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_tmo <= '0;
        end else if (r_state == S_OPEN) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_close = (w_voted_nxt == 3'b111);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_OPEN;
            S_OPEN:  if (w_close) w_state_nxt = S_TALLY;
            S_TALLY: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ballot   <= 3'b000;
            r_voted    <= 3'b000;
            r_dup_err  <= 1'b0;
            r_result   <= 4'b0000;
            r_majority <= 1'b0;
            r_hot_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ballot  <= 3'b000;
                        r_voted   <= 3'b000;
                        r_dup_err <= 1'b0;
                    end
                end
                S_OPEN: begin
                    // First strobe per voter wins; repeats only raise the sticky flag.
                    r_ballot <= (r_ballot & ~w_new_cast) | (choice & w_new_cast);
                    r_voted  <= w_voted_nxt;
                    if ((cast & r_voted) != 3'b000) begin
                        r_dup_err <= 1'b1;
                    end
                end
                S_TALLY: begin
                    r_result   <= R;
                    r_majority <= R[3] | R[2];
                    r_hot_err  <= ~w_r_onehot;
                end
                default: ;
            endcase
        end
    end

    // Non-voters are forced to "no" so a timed-out session tallies cleanly.
    assign V        = (r_state == S_TALLY) ? (r_ballot & r_voted) : 3'b000;
    assign busy     = (r_state == S_OPEN) || (r_state == S_TALLY);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign majority = r_majority;
    assign voted    = r_voted;
    assign dup_err  = r_dup_err;
    assign hot_err  = r_hot_err;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// Directed bench for vote_session_ctrl with a behavioural one-hot vote counter stub.
module tb_vote_session_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] cast;
    logic [2:0] choice;
    logic [2:0] V;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       majority;
    logic [2:0] voted;
    logic       dup_err;
    logic       hot_err;

    logic       force_r;
    logic [3:0] forced_r;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    // Counter stub: one-hot of the number of yes votes, or an injected value.
    always_comb begin
        R = 4'b0000;
        if (force_r) R = forced_r;
        else begin
            case (int'(V[0]) + int'(V[1]) + int'(V[2]))
                0:       R = 4'b0001;
                1:       R = 4'b0010;
                2:       R = 4'b0100;
                default: R = 4'b1000;
            endcase
        end
    end

    vote_session_ctrl #(.TMO_W(4), .TMO_CYCLES(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cast(cast), .choice(choice),
        .V(V), .R(R), .busy(busy), .done(done), .result(result),
        .majority(majority), .voted(voted), .dup_err(dup_err), .hot_err(hot_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cast = 3'b000; choice = 3'b000;
        force_r = 1'b0; forced_r = 4'b0000;
        tick();
        n_checks++;
        if ({V, busy, done, result, majority, voted, dup_err, hot_err} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got V=%b busy=%b done=%b result=%b maj=%b voted=%b dup=%b hot=%b, want all zero",
                     V, busy, done, result, majority, voted, dup_err, hot_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_at_once();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL open_busy: got %b want 1", busy); end
        cast = 3'b111; choice = 3'b101; tick(); cast = 3'b000;
        n_checks++;
        if (V !== 3'b101 || voted !== 3'b111) begin
            n_fail++; $display("FAIL tally_v: got V=%b voted=%b want V=101 voted=111", V, voted);
        end
        start = 1'b1; tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 4'b0100 || majority !== 1'b1) begin
            n_fail++;
            $display("FAIL done_once: got done=%b busy=%b result=%b maj=%b want 1 0 0100 1", done, busy, result, majority);
        end
        tick(); start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL start_in_done_ignored: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_staggered();
        start = 1'b1; tick(); start = 1'b0;
        cast = 3'b001; choice = 3'b001; tick();
        start = 1'b1;
        cast = 3'b100; choice = 3'b000; tick();
        start = 1'b0;
        cast = 3'b010; choice = 3'b000; tick(); cast = 3'b000;
        n_checks++;
        if (V !== 3'b001) begin n_fail++; $display("FAIL stagger_v: got %b want 001", V); end
        tick();
        n_checks++;
        if (done !== 1'b1 || result !== 4'b0010 || majority !== 1'b0 || dup_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_result: got done=%b result=%b maj=%b dup=%b want 1 0010 0 0", done, result, majority, dup_err);
        end
        tick();
    endtask

    task automatic test_duplicate();
        start = 1'b1; tick(); start = 1'b0;
        cast = 3'b010; choice = 3'b010; tick();
        cast = 3'b010; choice = 3'b000; tick();
        n_checks++;
        if (dup_err !== 1'b1 || voted !== 3'b010 || busy !== 1'b1) begin
            n_fail++; $display("FAIL dup_flag: got dup=%b voted=%b busy=%b want 1 010 1", dup_err, voted, busy);
        end
        cast = 3'b101; choice = 3'b101; tick(); cast = 3'b000;
        n_checks++;
        if (V !== 3'b111) begin n_fail++; $display("FAIL dup_ballot_kept: got V=%b want 111", V); end
        tick();
        n_checks++;
        if (result !== 4'b1000 || majority !== 1'b1 || dup_err !== 1'b1) begin
            n_fail++; $display("FAIL dup_result: got result=%b maj=%b dup=%b want 1000 1 1", result, majority, dup_err);
        end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (dup_err !== 1'b0 || voted !== 3'b000) begin
            n_fail++; $display("FAIL dup_cleared: got dup=%b voted=%b want 0 000", dup_err, voted);
        end
        cast = 3'b111; choice = 3'b000; tick(); cast = 3'b000;
        tick();
        n_checks++;
        if (result !== 4'b0001 || hot_err !== 1'b0 || majority !== 1'b0) begin
            n_fail++; $display("FAIL all_no: got result=%b hot=%b maj=%b want 0001 0 0", result, hot_err, majority);
        end
        tick();
    endtask

    task automatic test_hot_err();
        start = 1'b1; tick(); start = 1'b0;
        force_r = 1'b1; forced_r = 4'b0110;
        cast = 3'b111; choice = 3'b011; tick(); cast = 3'b000;
        tick();
        force_r = 1'b0;
        n_checks++;
        if (result !== 4'b0110 || hot_err !== 1'b1 || majority !== 1'b1) begin
            n_fail++; $display("FAIL hot_err: got result=%b hot=%b maj=%b want 0110 1 1", result, hot_err, majority);
        end
        tick();
    endtask

    task automatic test_timeout();
        int busy_cycles;
        start = 1'b1; tick(); start = 1'b0;
        cast = 3'b001; choice = 3'b001; tick(); cast = 3'b000;
`ifdef VOTE_TIMEOUT_EN
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || V !== 3'b000) begin
            n_fail++; $display("FAIL tmo_still_open: got busy=%b V=%b want 1 000", busy, V);
        end
        tick();
        n_checks++;
        if (V !== 3'b001) begin n_fail++; $display("FAIL tmo_tally_v: got %b want 001", V); end
        tick();
        n_checks++;
        if (done !== 1'b1 || result !== 4'b0010 || voted !== 3'b001) begin
            n_fail++; $display("FAIL tmo_result: got done=%b result=%b voted=%b want 1 0010 001", done, result, voted);
        end
        tick();
`else
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        n_checks++;
        if (busy_cycles != 100 || voted !== 3'b001) begin
            n_fail++; $display("FAIL no_tmo_wait: got busy_cycles=%0d voted=%b want 100 001", busy_cycles, voted);
        end
        cast = 3'b110; choice = 3'b000; tick(); cast = 3'b000;
        tick();
        n_checks++;
        if (done !== 1'b1 || result !== 4'b0010) begin
            n_fail++; $display("FAIL no_tmo_close: got done=%b result=%b want 1 0010", done, result);
        end
        tick();
`endif
    endtask

    task automatic test_mid_reset();
        int done_seen;
        start = 1'b1; tick(); start = 1'b0;
        cast = 3'b011; choice = 3'b011; tick(); cast = 3'b000;
        n_checks++;
        if (voted !== 3'b011) begin n_fail++; $display("FAIL pre_reset_voted: got %b want 011", voted); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++;
        if ({V, busy, done, result, majority, voted, dup_err, hot_err} !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_state: got V=%b busy=%b done=%b result=%b maj=%b voted=%b dup=%b hot=%b, want all zero",
                     V, busy, done, result, majority, voted, dup_err, hot_err);
        end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL aborted_no_done: got %0d pulses want 0", done_seen); end
        start = 1'b1; tick(); start = 1'b0;
        cast = 3'b111; choice = 3'b111; tick(); cast = 3'b000;
        tick();
        n_checks++;
        if (done !== 1'b1 || result !== 4'b1000 || voted !== 3'b111) begin
            n_fail++; $display("FAIL post_reset_session: got done=%b result=%b voted=%b want 1 1000 111", done, result, voted);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_all_at_once();
        test_staggered();
        test_duplicate();
        test_hot_err();
        test_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
